// File: rtl/bl_scan_ctrl.sv
// Bit-line mux scan sequencer.
// Walks channels first_ch..last_ch (wrapping modulo 8). Each channel gets a
// one-cycle break-before-make gap (EN=0, address driven), then settle_cyc
// cycles of EN=1, then a max(1,sample_cyc)-cycle sample window whose first
// cycle carries sample_strobe. All outputs are registered and are derived
// from the next state, so they line up with the state they describe.
module bl_scan_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             abort,
    input  logic             continuous,
    input  logic [2:0]       first_ch,
    input  logic [2:0]       last_ch,
    input  logic [CNT_W-1:0] settle_cyc,
    input  logic [CNT_W-1:0] sample_cyc,
    output logic             EN,
    output logic             A2,
    output logic             A1,
    output logic             A0,
    output logic [2:0]       cur_ch,
    output logic             sample_strobe,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        SETTLE = 2'd2,
        SAMPLE = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e             state_q, state_d;
    logic [2:0]         ch_q, ch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Configuration captured at start; inputs are ignored while busy.
    logic               cont_q, cont_d;
    logic [2:0]         first_q, first_d;
    logic [2:0]         last_q, last_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic [CNT_W-1:0]   sample_q, sample_d;

    // Registered outputs.
    logic               en_q, en_d;
    logic [2:0]         addr_q, addr_d;
    logic               strobe_q, strobe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // A zero sample length still gives a one-cycle window.
    logic [CNT_W-1:0]   samp_len;
    assign samp_len = (sample_q == '0) ? CNT_ONE : sample_q;

    // State, counters, captured config and output registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            cont_q   <= 1'b0;
            first_q  <= '0;
            last_q   <= '0;
            settle_q <= '0;
            sample_q <= '0;
            en_q     <= 1'b0;
            addr_q   <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            cont_q   <= cont_d;
            first_q  <= first_d;
            last_q   <= last_d;
            settle_q <= settle_d;
            sample_q <= sample_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; abort overrides everything and suppresses pulses.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        cont_d   = cont_q;
        first_d  = first_q;
        last_d   = last_q;
        settle_d = settle_q;
        sample_d = sample_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cont_d   = continuous;
                    first_d  = first_ch;
                    last_d   = last_ch;
                    settle_d = settle_cyc;
                    sample_d = sample_cyc;
                    ch_d     = first_ch;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (settle_q != '0) begin
                    state_d = SETTLE;
                    cnt_d   = settle_q - CNT_ONE;
                end else begin
                    state_d  = SAMPLE;
                    cnt_d    = samp_len - CNT_ONE;
                    strobe_d = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d  = SAMPLE;
                    cnt_d    = samp_len - CNT_ONE;
                    strobe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            SAMPLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (ch_q != last_q) begin
                    ch_d    = ch_q + 3'd1;
                    state_d = SETUP;
                end else begin
                    done_d = 1'b1;
                    if (cont_q) begin
                        ch_d    = first_q;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d  = IDLE;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end
    end

    // Output decode from the next state so outputs are registered yet in step.
    always_comb begin
        en_d   = (state_d == SETTLE) || (state_d == SAMPLE);
        busy_d = (state_d != IDLE);
        addr_d = (state_d == IDLE) ? 3'd0 : ch_d;
    end

    assign EN            = en_q;
    assign {A2, A1, A0}  = addr_q;
    assign cur_ch        = addr_q;
    assign sample_strobe = strobe_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_bl_scan_ctrl.sv
// Bench for bl_scan_ctrl: per-cycle pattern model plus a strobe-address
// scoreboard and invariant monitor.
module tb_bl_scan_ctrl;

    localparam int CNT_W = 4;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             continuous = 1'b0;
    logic [2:0]       first_ch = '0;
    logic [2:0]       last_ch = '0;
    logic [CNT_W-1:0] settle_cyc = '0;
    logic [CNT_W-1:0] sample_cyc = '0;
    logic             EN, A2, A1, A0, sample_strobe, busy, done;
    logic [2:0]       cur_ch;

    int n_chk = 0;
    int n_pass = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;
    logic [2:0] exp_q[$];
    logic [2:0] prev_addr = '0;

    bl_scan_ctrl #(.CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .abort(abort),
        .continuous(continuous), .first_ch(first_ch), .last_ch(last_ch),
        .settle_cyc(settle_cyc), .sample_cyc(sample_cyc),
        .EN(EN), .A2(A2), .A1(A1), .A0(A0), .cur_ch(cur_ch),
        .sample_strobe(sample_strobe), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    // Expected {EN, strobe, cur_ch, busy, done} at cycle k after SETUP entry.
    function automatic logic [6:0] exp_vec(input int first, input int settle,
                                           input int sample, input int nch,
                                           input bit cont, input int k);
        int p, total, kk, ph;
        logic [2:0] ch;
        p     = 1 + settle + ((sample == 0) ? 1 : sample);
        total = nch * p;
        if (!cont && k >= total) return 7'b0000001;
        kk = k % total;
        ph = kk % p;
        ch = 3'((first + kk / p) % 8);
        return {ph != 0, ph == settle + 1, ch, 1'b1, cont && k > 0 && kk == 0};
    endfunction

    // Scoreboard/invariant monitor, sampled away from the active edge.
    always @(negedge Clk) begin
        logic [2:0] e;
        if (Reset) begin
            if (cur_ch !== prev_addr) begin
                n_chk++;
                if (EN !== 1'b0) $display("FAIL bbm: EN=%b on address change to %0d, need 0", EN, cur_ch);
                else n_pass++;
            end
            if (sample_strobe === 1'b1) begin
                strobe_cnt++;
                n_chk++;
                if (EN !== 1'b1) $display("FAIL strobe_en: EN=%b during strobe, need 1", EN);
                else n_pass++;
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL strobe_unexp: strobe at ch %0d, none expected", cur_ch);
                end else begin
                    e = exp_q.pop_front();
                    if (cur_ch !== e || {A2, A1, A0} !== e)
                        $display("FAIL strobe_addr: got ch %0d A=%b%b%b, need %0d", cur_ch, A2, A1, A0, e);
                    else n_pass++;
                end
            end
            if (done === 1'b1) done_cnt++;
        end
        prev_addr = cur_ch;
    end

    // Launch a scan and push the expected strobe addresses for 'passes' passes.
    task automatic kick(input int f, input int l, input int st, input int sp,
                        input bit cont, input int passes, output int nch);
        logic [2:0] ch;
        nch = ((l - f) & 7) + 1;
        for (int p = 0; p < passes; p++) begin
            ch = 3'(f);
            for (int i = 0; i < nch; i++) begin
                exp_q.push_back(ch);
                ch = ch + 3'd1;
            end
        end
        @(negedge Clk);
        strobe_cnt = 0;
        done_cnt   = 0;
        first_ch   = 3'(f);
        last_ch    = 3'(l);
        settle_cyc = CNT_W'(st);
        sample_cyc = CNT_W'(sp);
        continuous = cont;
        start      = 1'b1;
        @(negedge Clk);
        start      = 1'b0;
    endtask

    task automatic test_reset();
        int nch;
        logic [6:0] got, ex;
        @(negedge Clk);
        n_chk++;
        got = {EN, sample_strobe, cur_ch, busy, done};
        if (got !== 7'b0 || {A2, A1, A0} !== 3'b0) $display("FAIL reset_state: got %b, need 0", got);
        else n_pass++;
        Reset = 1'b1;
        kick(3, 4, 3, 1, 1'b0, 0, nch);
        @(negedge Clk);
        n_chk++;
        if (EN !== 1'b1 || cur_ch !== 3'd3) $display("FAIL reset_presettle: EN=%b ch=%0d, need 1/3", EN, cur_ch);
        else n_pass++;
        #2 Reset = 1'b0;
        #1;
        n_chk++;
        got = {EN, sample_strobe, cur_ch, busy, done};
        if (got !== 7'b0 || {A2, A1, A0} !== 3'b0) $display("FAIL reset_async: got %b, need 0", got);
        else n_pass++;
        @(negedge Clk);
        Reset = 1'b1;
        kick(5, 5, 1, 1, 1'b0, 1, nch);
        for (int k = 0; k <= 3; k++) begin
            ex  = exp_vec(5, 1, 1, nch, 1'b0, k);
            got = {EN, sample_strobe, cur_ch, busy, done};
            n_chk++;
            if (got !== ex) $display("FAIL reset_restart k=%0d: got %b, need %b", k, got, ex);
            else n_pass++;
            @(negedge Clk);
        end
    endtask

    task automatic test_full_pass();
        int nch, total;
        logic [6:0] got, ex;
        kick(0, 7, 2, 1, 1'b0, 1, nch);
        total = nch * 4;
        for (int k = 0; k <= total; k++) begin
            ex  = exp_vec(0, 2, 1, nch, 1'b0, k);
            got = {EN, sample_strobe, cur_ch, busy, done};
            n_chk++;
            if (got !== ex) $display("FAIL full_pass k=%0d: got %b, need %b", k, got, ex);
            else n_pass++;
            @(negedge Clk);
        end
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL full_after: done=%b busy=%b, need 0/0", done, busy);
        else n_pass++;
        n_chk++;
        if (strobe_cnt != 8 || done_cnt != 1 || exp_q.size() != 0)
            $display("FAIL full_counts: strobes=%0d dones=%0d left=%0d, need 8/1/0", strobe_cnt, done_cnt, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_wrap();
        int nch, total, sp;
        logic [6:0] got, ex;
        for (int r = 0; r < 2; r++) begin
            sp = (r == 0) ? 3 : 0;
            kick(6, 1, 0, sp, 1'b0, 1, nch);
            total = nch * (1 + ((sp == 0) ? 1 : sp));
            for (int k = 0; k <= total; k++) begin
                ex  = exp_vec(6, 0, sp, nch, 1'b0, k);
                got = {EN, sample_strobe, cur_ch, busy, done};
                n_chk++;
                if (got !== ex) $display("FAIL wrap s%0d k=%0d: got %b, need %b", sp, k, got, ex);
                else n_pass++;
                @(negedge Clk);
            end
            n_chk++;
            if (strobe_cnt != 4 || done_cnt != 1 || exp_q.size() != 0)
                $display("FAIL wrap_counts s%0d: strobes=%0d dones=%0d, need 4/1", sp, strobe_cnt, done_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_continuous();
        int nch;
        logic [6:0] got, ex;
        kick(2, 3, 1, 1, 1'b1, 3, nch);
        for (int k = 0; k <= 17; k++) begin
            ex  = exp_vec(2, 1, 1, nch, 1'b1, k);
            got = {EN, sample_strobe, cur_ch, busy, done};
            n_chk++;
            if (got !== ex) $display("FAIL cont k=%0d: got %b, need %b", k, got, ex);
            else n_pass++;
            if (k == 17) abort = 1'b1;
            @(negedge Clk);
        end
        abort = 1'b0;
        got = {EN, sample_strobe, cur_ch, busy, done};
        n_chk++;
        if (got !== 7'b0) $display("FAIL cont_abort: got %b, need 0", got);
        else n_pass++;
        repeat (3) @(negedge Clk);
        n_chk++;
        if (busy !== 1'b0 || done_cnt != 2 || strobe_cnt != 6 || exp_q.size() != 0)
            $display("FAIL cont_counts: busy=%b dones=%0d strobes=%0d, need 0/2/6", busy, done_cnt, strobe_cnt);
        else n_pass++;
    endtask

    task automatic test_ignored();
        int nch;
        logic [6:0] got, ex;
        kick(1, 2, 1, 2, 1'b0, 1, nch);
        for (int k = 0; k <= 8; k++) begin
            ex  = exp_vec(1, 1, 2, nch, 1'b0, k);
            got = {EN, sample_strobe, cur_ch, busy, done};
            n_chk++;
            if (got !== ex) $display("FAIL ignored k=%0d: got %b, need %b", k, got, ex);
            else n_pass++;
            if (k == 2) begin
                start = 1'b1; first_ch = 3'd5; last_ch = 3'd7;
                settle_cyc = '0; continuous = 1'b1;
            end
            if (k == 3) start = 1'b0;
            @(negedge Clk);
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        abort = 1'b0;
        got = {EN, sample_strobe, cur_ch, busy, done};
        n_chk++;
        if (got !== 7'b0) $display("FAIL start_abort: got %b, need 0", got);
        else n_pass++;
        repeat (2) @(negedge Clk);
        n_chk++;
        if (busy !== 1'b0 || EN !== 1'b0) $display("FAIL start_abort_hold: busy=%b EN=%b, need 0/0", busy, EN);
        else n_pass++;
    endtask

    task automatic test_random();
        int nch, f, l, st, sp, total;
        logic [6:0] got, ex;
        int bad;
        for (int r = 0; r < 6; r++) begin
            f  = $urandom_range(7);
            l  = $urandom_range(7);
            st = $urandom_range(5);
            sp = $urandom_range(4);
            kick(f, l, st, sp, 1'b0, 1, nch);
            total = nch * (1 + st + ((sp == 0) ? 1 : sp));
            bad = 0;
            for (int k = 0; k <= total; k++) begin
                ex  = exp_vec(f, st, sp, nch, 1'b0, k);
                got = {EN, sample_strobe, cur_ch, busy, done};
                if (got !== ex && bad == 0) begin
                    bad = 1;
                    $display("FAIL random r%0d k=%0d f%0d l%0d st%0d sp%0d: got %b, need %b",
                             r, k, f, l, st, sp, got, ex);
                end
                @(negedge Clk);
            end
            n_chk++;
            if (bad == 0) n_pass++;
            n_chk++;
            if (strobe_cnt != nch || done_cnt != 1 || exp_q.size() != 0)
                $display("FAIL random_counts r%0d: strobes=%0d dones=%0d, need %0d/1", r, strobe_cnt, done_cnt, nch);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_wrap();
        test_continuous();
        test_ignored();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
